// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, issues sequential I-cache word reads and
// buffers {pc, instr} in a DEPTH-entry FIFO; flush empties it and redirects.
// Ports: clk, reset_n | imem_read/address/resp/rdata (I-cache side)
//        flush/flush_pc (redirect) | deq_valid/instr/pc/ready, count (core side)
`timescale 1ns/1ps

module fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic                     imem_read,
    output logic [31:0]              imem_address,
    input  logic                     imem_resp,
    input  logic [31:0]              imem_rdata,
    input  logic                     flush,
    input  logic [31:0]              flush_pc,
    output logic                     deq_valid,
    output logic [31:0]              deq_instr,
    output logic [31:0]              deq_pc,
    input  logic                     deq_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] req_addr, req_addr_nxt;
    logic [31:0] pc_inc;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW:0] count_nxt;
    logic        enq, deq;

    logic [31:0] mem_pc    [DEPTH];
    logic [31:0] mem_instr [DEPTH];

    assign count        = wr_ptr - rd_ptr;
    assign deq_valid    = (count != '0);
    assign deq_pc       = deq_valid ? mem_pc[rd_ptr[AW-1:0]] : '0;
    assign deq_instr    = deq_valid ? mem_instr[rd_ptr[AW-1:0]] : '0;
    assign imem_read    = (state == REQ) || (state == DROP);
    assign imem_address = req_addr;
    assign pc_inc       = req_addr + 32'd4;

    // A flush clears the queue, so neither side moves in that cycle.
    assign enq = (state == REQ) && imem_resp && !flush;
    assign deq = deq_valid && deq_ready && !flush;

    always_comb begin
        count_nxt = count;
        if (enq && !deq) begin
            count_nxt = count + ONE;
        end else if (deq && !enq) begin
            count_nxt = count - ONE;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_addr_nxt = req_addr;
        unique case (state)
            IDLE: begin
                if (flush) begin
                    fetch_pc_nxt = flush_pc;
                end else if (count < FULL_CNT) begin
                    req_addr_nxt = fetch_pc;
                    state_nxt    = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    fetch_pc_nxt = flush_pc;
                    if (imem_resp) begin
                        req_addr_nxt = flush_pc;
                    end else begin
                        // read stays up until the stale response returns
                        state_nxt = DROP;
                    end
                end else if (imem_resp) begin
                    fetch_pc_nxt = pc_inc;
                    if (count_nxt < FULL_CNT) begin
                        req_addr_nxt = pc_inc;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                if (flush) begin
                    fetch_pc_nxt = flush_pc;
                end
                if (imem_resp) begin
                    req_addr_nxt = flush ? flush_pc : fetch_pc;
                    state_nxt    = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_addr <= req_addr_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_pc[wr_ptr[AW-1:0]]    <= req_addr;
            mem_instr[wr_ptr[AW-1:0]] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with an I-cache responder,
// a negedge monitor, and directed flush / fill / wrap / reset scenarios.
`timescale 1ns/1ps

module tb_fetch_queue;

    localparam int          DEPTH = 8;
    localparam logic [31:0] RPC   = 32'h6000_0000;

    logic        clk;
    logic        reset_n;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic        deq_valid;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;
    logic        deq_ready;
    logic [3:0]  count;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .deq_valid    (deq_valid),
        .deq_instr    (deq_instr),
        .deq_pc       (deq_pc),
        .deq_ready    (deq_ready),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // stimulus controls (written by main only)
    bit auto_en;
    bit rnd_lat;
    bit rnd_ready;
    int man_req;

    // responder-owned
    int man_done;
    int resp_total;
    int cnt;
    int cur_lat;

    // monitor-owned model
    logic [63:0] exp_q[$];
    logic [63:0] ent;
    logic [31:0] exp_addr;
    logic [31:0] prev_addr;
    bit          prev_read;
    bit          prev_resp;
    bit          drop;
    int          pops;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (rnd_ready) deq_ready = ($urandom_range(0, 9) < 4);
    endtask

    // I-cache model: acts 2ns after each edge so main's settings are seen
    initial begin
        imem_resp  = 1'b0;
        imem_rdata = '0;
        man_done   = 0;
        resp_total = 0;
        cnt        = 0;
        cur_lat    = 2;
        forever begin
            @(posedge clk);
            #2;
            imem_resp = 1'b0;
            if (!reset_n) begin
                cnt      = 0;
                man_done = man_req;
            end else if (!auto_en) begin
                cnt = 0;
                if (man_req != man_done) begin
                    man_done++;
                    imem_resp  = 1'b1;
                    imem_rdata = instr_of(imem_address);
                    resp_total++;
                end
            end else if (imem_read) begin
                if (cnt >= cur_lat - 1) begin
                    imem_resp  = 1'b1;
                    imem_rdata = instr_of(imem_address);
                    resp_total++;
                    cnt        = 0;
                    cur_lat    = rnd_lat ? int'($urandom_range(1, 3)) : 2;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // monitor / scoreboard
    initial begin
        pops = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_read", imem_read, 0);
                chk("rst_addr", imem_address, RPC);
                chk("rst_valid", deq_valid, 0);
                chk("rst_count", count, 0);
                chk("rst_pc", deq_pc, 0);
                chk("rst_instr", deq_instr, 0);
                exp_q.delete();
                exp_addr  = RPC;
                drop      = 1'b0;
                prev_read = 1'b0;
                prev_resp = 1'b0;
                prev_addr = RPC;
            end else begin
                chk("count", count, exp_q.size());
                chk("deq_valid", deq_valid, exp_q.size() != 0);
                if (imem_read) begin
                    if (!prev_read || prev_resp)
                        chk("req_addr", imem_address, exp_addr);
                    else
                        chk("addr_stable", imem_address, prev_addr);
                end
                if (deq_valid && deq_ready && !flush) begin
                    if (exp_q.size() == 0) begin
                        chk("deq_unexpected", 1, 0);
                    end else begin
                        ent = exp_q.pop_front();
                        chk("deq_pc", deq_pc, ent[63:32]);
                        chk("deq_instr", deq_instr, ent[31:0]);
                        pops++;
                    end
                end
                if (flush) begin
                    exp_q.delete();
                    exp_addr = flush_pc;
                    drop     = imem_read && !imem_resp;
                end else if (imem_resp) begin
                    if (drop) begin
                        drop = 1'b0;
                    end else begin
                        exp_q.push_back({exp_addr, instr_of(exp_addr)});
                        exp_addr = exp_addr + 32'd4;
                    end
                end
                prev_read = imem_read;
                prev_resp = imem_resp;
                prev_addr = imem_address;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int p0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        flush_pc  = '0;
        deq_ready = 1'b0;
        auto_en   = 1'b1;
        rnd_lat   = 1'b0;
        rnd_ready = 1'b0;
        man_req   = 0;
        repeat (3) step();

        // fill from reset with back-pressure
        base    = resp_total;
        reset_n = 1'b1;
        step();
        chk("first_read", imem_read, 1);
        chk("first_addr", imem_address, RPC);
        for (int i = 0; i < 100 && !(imem_read == 1'b0 && count == 4'(DEPTH)); i++)
            step();
        chk("fill_count", count, DEPTH);
        chk("fill_read", imem_read, 0);
        chk("fill_resps", resp_total - base, 8);
        repeat (3) step();
        chk("full_hold_read", imem_read, 0);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        chk("pop_count", count, DEPTH - 1);
        step();
        chk("refill_read", imem_read, 1);
        chk("refill_addr", imem_address, RPC + 32'h20);

        // basic streaming fetch
        deq_ready = 1'b1;
        repeat (20) step();
        for (int i = 0; i < 20; i++) begin
            step();
            chk("basic_count_le1", count <= 4'd1, 1);
        end

        // flush during an outstanding request
        auto_en   = 1'b0;
        deq_ready = 1'b0;
        reset_n   = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
        man_req++;
        step();
        man_req++;
        step();
        chk("pre_flush_addr", imem_address, RPC + 32'h8);
        chk("pre_flush_count", count, 2);
        flush    = 1'b1;
        flush_pc = RPC + 32'h100;
        step();
        chk("drop_read", imem_read, 1);
        chk("drop_addr", imem_address, RPC + 32'h8);
        chk("flush_count", count, 0);
        chk("flush_valid", deq_valid, 0);
        step();
        chk("drop_addr2", imem_address, RPC + 32'h8);
        step();
        chk("drop_addr3", imem_address, RPC + 32'h8);
        man_req++;
        step();
        chk("redir_read", imem_read, 1);
        chk("redir_addr", imem_address, RPC + 32'h100);
        chk("redir_count", count, 0);

        // flush coincident with a response
        man_req++;
        step();
        chk("pre_coinc_count", count, 1);
        man_req++;
        flush    = 1'b1;
        flush_pc = RPC + 32'h200;
        step();
        chk("coinc_read", imem_read, 1);
        chk("coinc_addr", imem_address, RPC + 32'h200);
        chk("coinc_count", count, 0);
        man_req++;
        step();
        chk("coinc_deq_pc", deq_pc, RPC + 32'h200);
        chk("coinc_deq_instr", deq_instr, instr_of(RPC + 32'h200));

        // PC wrap at the top of the address space
        flush    = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        step();
        man_req++;
        step();
        chk("top_addr", imem_address, 32'hFFFF_FFFC);
        man_req++;
        step();
        chk("pc_wrap_addr", imem_address, 32'h0);
        chk("pc_wrap_deq", deq_pc, 32'hFFFF_FFFC);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;

        // random back-pressure with pointer wrap
        auto_en   = 1'b1;
        rnd_lat   = 1'b1;
        rnd_ready = 1'b1;
        p0        = pops;
        for (int i = 0; i < 2000 && pops - p0 < 40; i++)
            step();
        chk("wrap_pops", pops - p0 >= 40, 1);
        rnd_ready = 1'b0;
        deq_ready = 1'b0;

        // asynchronous reset mid-request
        for (int i = 0; i < 200 && !(count >= 4'd4 && imem_read); i++)
            step();
        chk("half_full", count >= 4'd4 && imem_read, 1);
        reset_n = 1'b0;
        #1;
        chk("async_read", imem_read, 0);
        chk("async_valid", deq_valid, 0);
        chk("async_count", count, 0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        chk("restart_read", imem_read, 1);
        chk("restart_addr", imem_address, RPC);
        deq_ready = 1'b1;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
